mha_attn_seq: RTL and testbench

- Parametrised multi-head attention sequencer that replaces the fixed 16x16 single-head controller.
- Tiles the computation over head, query row block, key column block and output column block.
- Issues tile commands (QK, SCALE, PV) to the SA wrapper through a valid/ready plus done handshake, and drives the row-wise softmax engine.
- Carries no matrix data, only indices and control, so it scales to any SEQ_LEN, D_K or head count.

---
 rtl/mha_attn_seq_if.sv | 64 ++++++
 rtl/mha_attn_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_mha_attn_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mha_attn_seq_if.sv
// mha_attn_seq_if
//   Command/control bundle between the attention sequencer, the systolic-array
//   wrapper and the softmax engine. Only indices and control travel here; no
//   matrix data.
//   Parameters mirror the sequencer so the index widths line up.
//   Signals (direction as seen by the sequencer):
//     I_ATTN_START  in   start pulse
//     O_CMD_VLD     out  command valid        I_CMD_RDY  in  command ready
//     O_CMD_OP      out  0=QK 1=SCALE 2=PV
//     O_CMD_HEAD/RBLK/CBLK  out  tile indices
//     O_CMD_MDIM    out  inner dimension      O_CMD_SCALE out  scale (SCALE only)
//     O_CMD_MASK    out  diagonal-tile mask
//     I_SA_DONE     in   command complete pulse
//     O_SM_START    out  softmax enable       O_SM_ROW   out  softmax row
//     I_SM_VLD      in   softmax row valid
//     O_TILE_DONE   out  tile pulse   O_DONE out job done   O_BUSY out   O_ERR out
//   Modports: master = sequencer side, slave = wrapper/softmax side.
interface mha_attn_seq_if #(
  parameter int SA_R    = 16,
  parameter int SA_C    = 16,
  parameter int SEQ_LEN = 64,
  parameter int D_K     = 128,
  parameter int H_NUM   = 4
);
  localparam int NRB    = SEQ_LEN / SA_R;
  localparam int CB_MAX = ((SEQ_LEN > D_K) ? SEQ_LEN : D_K) / SA_C;
  localparam int HEAD_W = (H_NUM > 1) ? $clog2(H_NUM) : 1;
  localparam int RBLK_W = (NRB > 1) ? $clog2(NRB) : 1;
  localparam int CBLK_W = (CB_MAX > 1) ? $clog2(CB_MAX) : 1;
  localparam int ROW_W  = (SA_R > 1) ? $clog2(SA_R) : 1;

  logic              I_ATTN_START;
  logic              O_CMD_VLD;
  logic              I_CMD_RDY;
  logic [1:0]        O_CMD_OP;
  logic [HEAD_W-1:0] O_CMD_HEAD;
  logic [RBLK_W-1:0] O_CMD_RBLK;
  logic [CBLK_W-1:0] O_CMD_CBLK;
  logic [15:0]       O_CMD_MDIM;
  logic [7:0]        O_CMD_SCALE;
  logic              O_CMD_MASK;
  logic              I_SA_DONE;
  logic              O_SM_START;
  logic [ROW_W-1:0]  O_SM_ROW;
  logic              I_SM_VLD;
  logic              O_TILE_DONE;
  logic              O_DONE;
  logic              O_BUSY;
  logic              O_ERR;

  modport master (
    input  I_ATTN_START, I_CMD_RDY, I_SA_DONE, I_SM_VLD,
    output O_CMD_VLD, O_CMD_OP, O_CMD_HEAD, O_CMD_RBLK, O_CMD_CBLK, O_CMD_MDIM,
           O_CMD_SCALE, O_CMD_MASK, O_SM_START, O_SM_ROW, O_TILE_DONE, O_DONE,
           O_BUSY, O_ERR
  );

  modport slave (
    output I_ATTN_START, I_CMD_RDY, I_SA_DONE, I_SM_VLD,
    input  O_CMD_VLD, O_CMD_OP, O_CMD_HEAD, O_CMD_RBLK, O_CMD_CBLK, O_CMD_MDIM,
           O_CMD_SCALE, O_CMD_MASK, O_SM_START, O_SM_ROW, O_TILE_DONE, O_DONE,
           O_BUSY, O_ERR
  );
endinterface

// File: rtl/mha_attn_seq.sv
// mha_attn_seq
//   Multi-head attention sequencer. Walks head h, query row block r, key block c
//   and output block p, issuing QK/SCALE/PV tile commands over a valid/ready
//   handshake (completion signalled by I_SA_DONE) and feeding the softmax engine
//   one row at a time between the score and PV phases.
//   Ports:
//     I_CLK        clock
//     I_ASYN_RSTN  asynchronous active-low reset
//     bus          mha_attn_seq_if.master (command, softmax and status signals)
//   Optional build macro CAUSAL_MASK_EN: only key blocks c<=r are scored, the
//   diagonal block carries O_CMD_MASK=1 and the PV inner dimension shrinks to
//   (r+1)*SA_R. Requires SA_R==SA_C. Without the macro the mask is always 0.
//   Every output is a flop so reset clears all outputs immediately.
module mha_attn_seq #(
  parameter int SA_R      = 16,
  parameter int SA_C      = 16,
  parameter int SEQ_LEN   = 64,
  parameter int D_K       = 128,
  parameter int H_NUM     = 4,
  parameter int SCALE_VAL = 3
) (
  input  logic          I_CLK,
  input  logic          I_ASYN_RSTN,
  mha_attn_seq_if.master bus
);
  localparam int NRB    = SEQ_LEN / SA_R;
  localparam int NCB    = SEQ_LEN / SA_C;
  localparam int NPB    = D_K / SA_C;
  localparam int CB_MAX = ((SEQ_LEN > D_K) ? SEQ_LEN : D_K) / SA_C;
  localparam int HEAD_W = (H_NUM > 1) ? $clog2(H_NUM) : 1;
  localparam int RBLK_W = (NRB > 1) ? $clog2(NRB) : 1;
  localparam int CBLK_W = (CB_MAX > 1) ? $clog2(CB_MAX) : 1;
  localparam int ROW_W  = (SA_R > 1) ? $clog2(SA_R) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_QK_ISSUE, S_QK_WAIT, S_SC_ISSUE, S_SC_WAIT,
    S_SM_RUN, S_PV_ISSUE, S_PV_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [HEAD_W-1:0] h_q, h_d;
  logic [RBLK_W-1:0] r_q, r_d;
  logic [CBLK_W-1:0] c_q, c_d;
  logic [CBLK_W-1:0] p_q, p_d;
  logic [ROW_W-1:0]  row_q, row_d;

  logic              cmd_vld_q, cmd_vld_d;
  logic [1:0]        cmd_op_q, cmd_op_d;
  logic [HEAD_W-1:0] cmd_head_q, cmd_head_d;
  logic [RBLK_W-1:0] cmd_rblk_q, cmd_rblk_d;
  logic [CBLK_W-1:0] cmd_cblk_q, cmd_cblk_d;
  logic [15:0]       cmd_mdim_q, cmd_mdim_d;
  logic [7:0]        cmd_scale_q, cmd_scale_d;
  logic              cmd_mask_q, cmd_mask_d;
  logic              sm_start_q, sm_start_d;
  logic              tile_done_q, tile_done_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic c_last;   // current key block is the last one scored for this row block
  logic diag_d;   // next command sits on the diagonal tile
  logic [15:0] pv_mdim_d;

`ifdef CAUSAL_MASK_EN
  assign c_last    = (32'(c_q) == 32'(r_q));
  assign diag_d    = (32'(c_d) == 32'(r_d));
  assign pv_mdim_d = 16'((32'(r_d) + 1) * SA_R);
`else
  assign c_last    = (c_q == CBLK_W'(NCB - 1));
  assign diag_d    = 1'b0;
  assign pv_mdim_d = 16'(SEQ_LEN);
`endif

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    r_d     = r_q;
    c_d     = c_q;
    p_d     = p_q;
    row_d   = row_q;
    done_d  = done_q;
    err_d   = err_q;

    // Protocol errors: completion outside a wait, softmax result outside SM_RUN.
    if (bus.I_SA_DONE && !(state_q inside {S_QK_WAIT, S_SC_WAIT, S_PV_WAIT}))
      err_d = 1'b1;
    if (bus.I_SM_VLD && (state_q != S_SM_RUN))
      err_d = 1'b1;

    case (state_q)
      S_IDLE: if (bus.I_ATTN_START) begin
        state_d = S_QK_ISSUE;
        h_d     = '0;
        r_d     = '0;
        c_d     = '0;
        p_d     = '0;
        row_d   = '0;
        done_d  = 1'b0;
      end
      S_QK_ISSUE: if (bus.I_CMD_RDY) state_d = S_QK_WAIT;
      S_QK_WAIT:  if (bus.I_SA_DONE) state_d = S_SC_ISSUE;
      S_SC_ISSUE: if (bus.I_CMD_RDY) state_d = S_SC_WAIT;
      S_SC_WAIT: if (bus.I_SA_DONE) begin
        if (c_last) begin
          c_d     = '0;
          state_d = S_SM_RUN;
        end else begin
          c_d     = c_q + 1'b1;
          state_d = S_QK_ISSUE;
        end
      end
      S_SM_RUN: if (bus.I_SM_VLD) begin
        if (row_q == ROW_W'(SA_R - 1)) begin
          row_d   = '0;
          state_d = S_PV_ISSUE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_PV_ISSUE: if (bus.I_CMD_RDY) state_d = S_PV_WAIT;
      S_PV_WAIT: if (bus.I_SA_DONE) begin
        if (p_q == CBLK_W'(NPB - 1)) begin
          p_d     = '0;
          state_d = S_NEXT;
        end else begin
          p_d     = p_q + 1'b1;
          state_d = S_PV_ISSUE;
        end
      end
      S_NEXT: begin
        state_d = S_QK_ISSUE;
        if (r_q == RBLK_W'(NRB - 1)) begin
          r_d = '0;
          if (h_q == HEAD_W'(H_NUM - 1)) begin
            h_d     = '0;
            state_d = S_DONE;
          end else begin
            h_d = h_q + 1'b1;
          end
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) done_d = 1'b1;

    // Outputs are decoded from the next state so they are registered yet line
    // up with the state they belong to; fields stay frozen during a stall
    // because state and counters do not move until the handshake.
    cmd_vld_d   = state_d inside {S_QK_ISSUE, S_SC_ISSUE, S_PV_ISSUE};
    cmd_op_d    = 2'd0;
    cmd_head_d  = '0;
    cmd_rblk_d  = '0;
    cmd_cblk_d  = '0;
    cmd_mdim_d  = '0;
    cmd_scale_d = '0;
    cmd_mask_d  = 1'b0;
    if (cmd_vld_d) begin
      cmd_head_d = h_d;
      cmd_rblk_d = r_d;
      case (state_d)
        S_QK_ISSUE: begin
          cmd_op_d   = 2'd0;
          cmd_cblk_d = c_d;
          cmd_mdim_d = 16'(D_K);
          cmd_mask_d = diag_d;
        end
        S_SC_ISSUE: begin
          cmd_op_d    = 2'd1;
          cmd_cblk_d  = c_d;
          cmd_mdim_d  = 16'(SA_C);
          cmd_scale_d = 8'(SCALE_VAL);
          cmd_mask_d  = diag_d;
        end
        default: begin
          cmd_op_d   = 2'd2;
          cmd_cblk_d = p_d;
          cmd_mdim_d = pv_mdim_d;
        end
      endcase
    end
    sm_start_d  = (state_d == S_SM_RUN);
    tile_done_d = (state_d == S_NEXT);
    busy_d      = !(state_d inside {S_IDLE, S_DONE});
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      p_q         <= '0;
      row_q       <= '0;
      cmd_vld_q   <= 1'b0;
      cmd_op_q    <= 2'd0;
      cmd_head_q  <= '0;
      cmd_rblk_q  <= '0;
      cmd_cblk_q  <= '0;
      cmd_mdim_q  <= '0;
      cmd_scale_q <= '0;
      cmd_mask_q  <= 1'b0;
      sm_start_q  <= 1'b0;
      tile_done_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      r_q         <= r_d;
      c_q         <= c_d;
      p_q         <= p_d;
      row_q       <= row_d;
      cmd_vld_q   <= cmd_vld_d;
      cmd_op_q    <= cmd_op_d;
      cmd_head_q  <= cmd_head_d;
      cmd_rblk_q  <= cmd_rblk_d;
      cmd_cblk_q  <= cmd_cblk_d;
      cmd_mdim_q  <= cmd_mdim_d;
      cmd_scale_q <= cmd_scale_d;
      cmd_mask_q  <= cmd_mask_d;
      sm_start_q  <= sm_start_d;
      tile_done_q <= tile_done_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.O_CMD_VLD   = cmd_vld_q;
  assign bus.O_CMD_OP    = cmd_op_q;
  assign bus.O_CMD_HEAD  = cmd_head_q;
  assign bus.O_CMD_RBLK  = cmd_rblk_q;
  assign bus.O_CMD_CBLK  = cmd_cblk_q;
  assign bus.O_CMD_MDIM  = cmd_mdim_q;
  assign bus.O_CMD_SCALE = cmd_scale_q;
  assign bus.O_CMD_MASK  = cmd_mask_q;
  assign bus.O_SM_START  = sm_start_q;
  assign bus.O_SM_ROW    = row_q;
  assign bus.O_TILE_DONE = tile_done_q;
  assign bus.O_DONE      = done_q;
  assign bus.O_BUSY      = busy_q;
  assign bus.O_ERR       = err_q;
endmodule

// File: tb/tb_mha_attn_seq.sv
// tb_mha_attn_seq
//   Directed bench for mha_attn_seq with SEQ_LEN=32, D_K=32, H_NUM=2, 16x16 array.
//   A responder acts as SA wrapper (done 3 cycles after accept) and softmax engine
//   (one row result per cycle while enabled); accepted commands, softmax rows and
//   tile pulses are logged and compared against hand-derived job sequences.
module tb_mha_attn_seq;
  localparam int SA_R = 16, SA_C = 16, SEQ_LEN = 32, D_K = 32, H_NUM = 2, SCALE_VAL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mha_attn_seq_if #(.SA_R(SA_R), .SA_C(SA_C), .SEQ_LEN(SEQ_LEN), .D_K(D_K), .H_NUM(H_NUM)) bus ();

  mha_attn_seq #(.SA_R(SA_R), .SA_C(SA_C), .SEQ_LEN(SEQ_LEN), .D_K(D_K), .H_NUM(H_NUM),
                 .SCALE_VAL(SCALE_VAL)) dut (
    .I_CLK(clk),
    .I_ASYN_RSTN(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_cmd(input int op, input int head, input int rblk,
                                           input int cblk, input int mdim, input int scale,
                                           input int mask);
    logic [31:0] w;
    w = {2'b00, op[1:0], head[0], rblk[0], cblk[0], mdim[15:0], scale[7:0], mask[0]};
    return w;
  endfunction

  function automatic logic [31:0] cur_cmd();
    return pack_cmd(int'(bus.O_CMD_OP), int'(bus.O_CMD_HEAD), int'(bus.O_CMD_RBLK),
                    int'(bus.O_CMD_CBLK), int'(bus.O_CMD_MDIM), int'(bus.O_CMD_SCALE),
                    int'(bus.O_CMD_MASK));
  endfunction

  logic [31:0] acc_q[$];
  int          tile_q[$];
  int          sm_rows[$];
  int          sa_cnt = 0;
  int          last_hr = 0;
  logic        inj_sa_done = 1'b0;

  // Responder: evaluates just after each falling edge, after the main thread's drives.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      sa_cnt = 0;
      bus.I_SA_DONE = 1'b0;
      bus.I_SM_VLD = 1'b0;
    end else begin
      bus.I_SA_DONE = inj_sa_done;
      if (sa_cnt > 0) begin
        sa_cnt--;
        if (sa_cnt == 0) bus.I_SA_DONE = 1'b1;
      end
      if (bus.O_CMD_VLD && bus.I_CMD_RDY) begin
        acc_q.push_back(cur_cmd());
        last_hr = int'(bus.O_CMD_HEAD) * 2 + int'(bus.O_CMD_RBLK);
        sa_cnt = 3;
        $display("cmd op=%0d h=%0d r=%0d c=%0d mdim=%0d scale=%0d mask=%0d",
                 bus.O_CMD_OP, bus.O_CMD_HEAD, bus.O_CMD_RBLK, bus.O_CMD_CBLK,
                 bus.O_CMD_MDIM, bus.O_CMD_SCALE, bus.O_CMD_MASK);
      end
      bus.I_SM_VLD = bus.O_SM_START;
      if (bus.O_SM_START) sm_rows.push_back(int'(bus.O_SM_ROW));
      if (bus.O_TILE_DONE) begin
        tile_q.push_back(last_hr);
        $display("tile_done h=%0d r=%0d", last_hr / 2, last_hr % 2);
      end
    end
  end

  task automatic clear_logs();
    acc_q.delete();
    tile_q.delete();
    sm_rows.delete();
  endtask

  // Called at a falling edge; returns one cycle later, after the start was sampled.
  task automatic start_job();
    bus.I_ATTN_START = 1'b1;
    @(negedge clk);
    bus.I_ATTN_START = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!bus.O_DONE && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " done_reached"}, 32'(bus.O_DONE), 1);
  endtask

  // Expected job: per (h,r) tile QK/SC for each key block, then PV for each output
  // block; MDIM 32/16/32, SCALE 3 only on op 1.
  task automatic check_job(input string tag);
    logic [31:0] exp_q[$];
    int clim, mdim_pv, diag, n;
    for (int h = 0; h < 2; h++) begin
      for (int r = 0; r < 2; r++) begin
`ifdef CAUSAL_MASK_EN
        clim = r;
        mdim_pv = 16 * (r + 1);
`else
        clim = 1;
        mdim_pv = 32;
`endif
        for (int c = 0; c <= clim; c++) begin
`ifdef CAUSAL_MASK_EN
          diag = (c == r) ? 1 : 0;
`else
          diag = 0;
`endif
          exp_q.push_back(pack_cmd(0, h, r, c, 32, 0, diag));
          exp_q.push_back(pack_cmd(1, h, r, c, 16, 3, diag));
        end
        for (int p = 0; p < 2; p++) exp_q.push_back(pack_cmd(2, h, r, p, mdim_pv, 0, 0));
      end
    end
    check_eq({tag, " ncmd"}, acc_q.size(), exp_q.size());
    n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s cmd%0d", tag, i), acc_q[i], exp_q[i]);
    check_eq({tag, " ntile"}, tile_q.size(), 4);
    n = (tile_q.size() < 4) ? tile_q.size() : 4;
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s tile%0d_hr", tag, i), tile_q[i], i);
    check_eq({tag, " nsmrow"}, sm_rows.size(), 64);
    n = (sm_rows.size() < 64) ? sm_rows.size() : 64;
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s smrow%0d", tag, i), sm_rows[i], i % 16);
  endtask

  logic [31:0] snap;
  int n_wait;

  initial begin
    bus.I_ATTN_START = 1'b0;
    bus.I_CMD_RDY = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_vld", 32'(bus.O_CMD_VLD), 0);
    check_eq("rst_busy", 32'(bus.O_BUSY), 0);
    check_eq("rst_done", 32'(bus.O_DONE), 0);
    check_eq("rst_err", 32'(bus.O_ERR), 0);
    check_eq("rst_sm", 32'(bus.O_SM_START), 0);
    check_eq("rst_cmd", cur_cmd(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Job 1: ready always high
    clear_logs();
    check_eq("t1_busy_pre", 32'(bus.O_BUSY), 0);
    start_job();
    check_eq("t1_busy_rise", 32'(bus.O_BUSY), 1);
    check_eq("t1_vld_rise", 32'(bus.O_CMD_VLD), 1);
    wait_done("t1");
    check_job("t1");
    check_eq("t1_busy_end", 32'(bus.O_BUSY), 0);
    check_eq("t1_err", 32'(bus.O_ERR), 0);
    repeat (3) @(negedge clk);
    check_eq("t1_done_hold", 32'(bus.O_DONE), 1);

    // Job 2: first command stalled five cycles
    clear_logs();
    bus.I_CMD_RDY = 1'b0;
    start_job();
    check_eq("t2_done_clr", 32'(bus.O_DONE), 0);
    snap = cur_cmd();
    check_eq("t2_first_cmd", snap, pack_cmd(0, 0, 0, 0, 32, 0, 0));
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t2_vld%0d", i), 32'(bus.O_CMD_VLD), 1);
      check_eq($sformatf("t2_hold%0d", i), cur_cmd(), snap);
      @(negedge clk);
    end
    check_eq("t2_vld5", 32'(bus.O_CMD_VLD), 1);
    check_eq("t2_hold5", cur_cmd(), snap);
    bus.I_CMD_RDY = 1'b1;
    @(negedge clk);
    check_eq("t2_vld_drop", 32'(bus.O_CMD_VLD), 0);
    wait_done("t2");
    check_job("t2");

    // Job 3: extra start mid-job, then a stray SA done while idle
    clear_logs();
    start_job();
    repeat (20) @(negedge clk);
    start_job();
    check_eq("t3_busy_mid", 32'(bus.O_BUSY), 1);
    wait_done("t3");
    check_job("t3");
    check_eq("t3_err_clean", 32'(bus.O_ERR), 0);
    repeat (2) @(negedge clk);
    inj_sa_done = 1'b1;
    @(negedge clk);
    inj_sa_done = 1'b0;
    check_eq("t3_err_set", 32'(bus.O_ERR), 1);
    repeat (5) @(negedge clk);
    check_eq("t3_err_sticky", 32'(bus.O_ERR), 1);
    check_eq("t3_done_kept", 32'(bus.O_DONE), 1);

    // Job 4: reset while softmax is on row 7, then a fresh job
    clear_logs();
    start_job();
    n_wait = 0;
    while (!(bus.O_SM_START && bus.O_SM_ROW == 4'd7) && n_wait < 500) begin
      @(negedge clk);
      n_wait++;
    end
    check_eq("t4_sm_start", 32'(bus.O_SM_START), 1);
    check_eq("t4_row7", 32'(bus.O_SM_ROW), 7);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t4_rst_sm", 32'(bus.O_SM_START), 0);
    check_eq("t4_rst_row", 32'(bus.O_SM_ROW), 0);
    check_eq("t4_rst_busy", 32'(bus.O_BUSY), 0);
    check_eq("t4_rst_err", 32'(bus.O_ERR), 0);
    check_eq("t4_rst_vld", 32'(bus.O_CMD_VLD), 0);
    check_eq("t4_rst_cmd", cur_cmd(), 0);
    repeat (3) @(negedge clk);
    check_eq("t4_quiet_tile", 32'(bus.O_TILE_DONE), 0);
    check_eq("t4_quiet_done", 32'(bus.O_DONE), 0);
    rst_n = 1'b1;
    clear_logs();
    @(negedge clk);
    start_job();
    check_eq("t4_restart_cmd", cur_cmd(), pack_cmd(0, 0, 0, 0, 32, 0, 0));
    wait_done("t4");
    check_job("t4");
    check_eq("t4_err", 32'(bus.O_ERR), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
